// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and helpers
// Purpose: default 800x600@72 timing, derived totals and counter width,
//          shared by the timing generator, renderers and testbenches.
// Ports:   none (package).
package vga_pkg;

  localparam int CNT_W = 16;
  localparam int MAX_LEAD = 4;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BACK    = 64;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BACK    = 23;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_frame_timing_if.sv
// rtl/vga_frame_timing_if.sv - raster timing bundle between generator and renderers
// Purpose: groups pixel coordinates, sync/de and frame signals.
// Ports:   none; modport master drives the bundle, modport slave observes it.
interface vga_frame_timing_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             pixel_valid;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             new_frame;
  logic [CNT_W-1:0] frame_count;

  modport master (
    output pixel_x, pixel_y, pixel_valid, hsync, vsync, de, new_frame, frame_count
  );

  modport slave (
    input pixel_x, pixel_y, pixel_valid, hsync, vsync, de, new_frame, frame_count
  );

endinterface

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - N-stage single-bit shift register with reset value
// Purpose: aligns raw sync/enable signals with the lead of the pixel coordinates.
// Ports:   clk, rst (sync active-high), d (input bit), q (d delayed N cycles).
module sync_delay #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (N == 0) begin : g_pass
    // Zero stages: straight wire, clock and reset intentionally unused.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    logic [N-1:0] sr;

    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= {N{RST_VAL}};
      end else begin
        sr[0] <= d;
        for (int i = 1; i < N; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[N-1];
  end

endmodule

// File: rtl/vga_frame_timing.sv
// rtl/vga_frame_timing.sv - VGA raster counters, syncs, display enable and frame pulse
// Purpose: generates h/v counters; pixel coordinates lead hsync/vsync/de by LEAD
//          cycles so renderers with memory latency line up with the output.
// Ports:   clk (pixel clock), rst (sync active-high),
//          vga (master): pixel_x/pixel_y/pixel_valid, hsync, vsync, de,
//          new_frame (1-cycle pulse at start of vertical blanking), frame_count.
module vga_frame_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LEAD      = 2
) (
  input logic                clk,
  input logic                rst,
  vga_frame_timing_if.master vga
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_total_check
    $error("vga_frame_timing: H_TOTAL/V_TOTAL exceed the 16-bit counter range");
  end

  if (LEAD < 0 || LEAD > MAX_LEAD) begin : g_lead_check
    $error("vga_frame_timing: LEAD must be within 0..4");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic             new_frame_q;

  logic hs_raw;
  logic vs_raw;
  logic valid_raw;
  logic hs_d;
  logic vs_d;
  logic de_d;
  logic blank_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hs_raw    = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw    = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign valid_raw = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);

  // First cycle of the first blanking line; the pulse appears one cycle later
  // because new_frame is registered, and a reset mid-frame suppresses it until
  // the counters come back around to this point.
  assign blank_start = (h_cnt == '0) && (v_cnt == V_VIS_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      new_frame_q <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      new_frame_q <= blank_start;
      if (blank_start) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stages reset to 0, which maps to the inactive sync level after polarity.
  sync_delay #(.N(LEAD), .RST_VAL(1'b0)) u_hs_delay (
    .clk (clk),
    .rst (rst),
    .d   (hs_raw),
    .q   (hs_d)
  );

  sync_delay #(.N(LEAD), .RST_VAL(1'b0)) u_vs_delay (
    .clk (clk),
    .rst (rst),
    .d   (vs_raw),
    .q   (vs_d)
  );

  sync_delay #(.N(LEAD), .RST_VAL(1'b0)) u_de_delay (
    .clk (clk),
    .rst (rst),
    .d   (valid_raw),
    .q   (de_d)
  );

  assign vga.pixel_x     = h_cnt;
  assign vga.pixel_y     = v_cnt;
  assign vga.pixel_valid = valid_raw;
  assign vga.hsync       = ~(hs_d ^ HS_POL);
  assign vga.vsync       = ~(vs_d ^ VS_POL);
  assign vga.de          = de_d;
  assign vga.new_frame   = new_frame_q;
  assign vga.frame_count = frame_cnt;

endmodule
